// File: rtl/pattern_sweeper.sv
// Exhaustive 9-input stimulus sweeper: drives all 512 vectors on A..I, samples X after a settle
// delay, and accumulates a ones count and CRC-16 signature. Optional abort via SWEEP_ABORT_EN.
module pattern_sweeper #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
`ifdef SWEEP_ABORT_EN
  input  logic        ABORT,
`endif
  input  logic        X,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        E,
  output logic        F,
  output logic        G,
  output logic        H,
  output logic        I,
  output logic        BUSY,
  output logic        DONE,
  output logic [9:0]  ONES,
  output logic [15:0] SIG
);

  localparam logic [3:0] LastWait = 4'(SETTLE - 1);

  typedef enum logic [1:0] {StIdle, StWait, StSample} state_e;

  state_e      r_state, w_state_d;
  logic [8:0]  r_idx, w_idx_d;
  logic [3:0]  r_wcnt, w_wcnt_d;
  logic        r_busy, w_busy_d;
  logic        r_done, w_done_d;
  logic [9:0]  r_ones, w_ones_d;
  logic [15:0] r_sig, w_sig_d;

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_wcnt_d  = r_wcnt;
    w_busy_d  = r_busy;
    w_done_d  = 1'b0;
    w_ones_d  = r_ones;
    w_sig_d   = r_sig;
    case (r_state)
      StIdle: begin
        if (START) begin
          w_idx_d   = 9'd0;
          w_wcnt_d  = 4'd0;
          w_ones_d  = 10'd0;
          w_sig_d   = 16'hFFFF;
          w_busy_d  = 1'b1;
          w_state_d = StWait;
        end
      end
      StWait: begin
        w_wcnt_d = r_wcnt + 4'd1;
        if (r_wcnt == LastWait) w_state_d = StSample;
      end
      StSample: begin
        w_ones_d = r_ones + 10'(X);
        w_sig_d  = {r_sig[14:0], 1'b0} ^ ((r_sig[15] ^ X) ? 16'h1021 : 16'h0000);
        if (r_idx == 9'd511) begin
          // A..I return to zero because they are driven straight from the index
          w_idx_d   = 9'd0;
          w_busy_d  = 1'b0;
          w_done_d  = 1'b1;
          w_state_d = StIdle;
        end else begin
          w_idx_d   = r_idx + 9'd1;
          w_wcnt_d  = 4'd0;
          w_state_d = StWait;
        end
      end
      default: w_state_d = StIdle;
    endcase
`ifdef SWEEP_ABORT_EN
    // Abort keeps the partial ONES/SIG so software can inspect how far the sweep got
    if (ABORT && (r_state != StIdle)) begin
      w_idx_d   = 9'd0;
      w_wcnt_d  = 4'd0;
      w_busy_d  = 1'b0;
      w_done_d  = 1'b0;
      w_ones_d  = r_ones;
      w_sig_d   = r_sig;
      w_state_d = StIdle;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= StIdle;
      r_idx   <= 9'd0;
      r_wcnt  <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ones  <= 10'd0;
      r_sig   <= 16'hFFFF;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_wcnt  <= w_wcnt_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_ones  <= w_ones_d;
      r_sig   <= w_sig_d;
    end
  end

  assign {A, B, C, D, E, F, G, H, I} = r_idx;
  assign BUSY = r_busy;
  assign DONE = r_done;
  assign ONES = r_ones;
  assign SIG  = r_sig;

endmodule

// File: tb/tb_pattern_sweeper.sv
// Bench for pattern_sweeper: SETTLE=1 and SETTLE=3 instances, table of X response patterns
// checked against a vector-indexed model, plus reset, held-START and (optional) abort sequences.
module tb_pattern_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, sel, x;
  int   mode;
  logic rnd [512];
`ifdef SWEEP_ABORT_EN
  logic abort;
`endif

  wire        start1 = start & ~sel;
  wire        start3 = start & sel;
  wire [8:0]  vec1, vec3;
  wire        busy1, busy3, done1, done3;
  wire [9:0]  ones1, ones3;
  wire [15:0] sig1, sig3;

  wire [8:0]  vec_s  = sel ? vec3  : vec1;
  wire        busy_s = sel ? busy3 : busy1;
  wire        done_s = sel ? done3 : done1;
  wire [9:0]  ones_s = sel ? ones3 : ones1;
  wire [15:0] sig_s  = sel ? sig3  : sig1;

  pattern_sweeper #(.SETTLE(1)) dut (
    .CLK(clk), .RST(rst), .START(start1),
`ifdef SWEEP_ABORT_EN
    .ABORT(abort),
`endif
    .X(x),
    .A(vec1[8]), .B(vec1[7]), .C(vec1[6]), .D(vec1[5]), .E(vec1[4]),
    .F(vec1[3]), .G(vec1[2]), .H(vec1[1]), .I(vec1[0]),
    .BUSY(busy1), .DONE(done1), .ONES(ones1), .SIG(sig1)
  );

  pattern_sweeper #(.SETTLE(3)) dut3 (
    .CLK(clk), .RST(rst), .START(start3),
`ifdef SWEEP_ABORT_EN
    .ABORT(abort),
`endif
    .X(x),
    .A(vec3[8]), .B(vec3[7]), .C(vec3[6]), .D(vec3[5]), .E(vec3[4]),
    .F(vec3[3]), .G(vec3[2]), .H(vec3[1]), .I(vec3[0]),
    .BUSY(busy3), .DONE(done3), .ONES(ones3), .SIG(sig3)
  );

  // Circuit-under-test response for a given vector: 0 tie-1, 1 tie-0, 2 X=A, 3 X=AND, 4 random
  function automatic logic xf(input int m, input logic [8:0] v);
    case (m)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return v[8];
      3:       return &v;
      default: return rnd[v];
    endcase
  endfunction

  always_comb x = xf(mode, vec_s);

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic model(input int m, output int ones, output logic [15:0] sig);
    logic b;
    ones = 0;
    sig  = 16'hFFFF;
    for (int v = 0; v < 512; v++) begin
      b = xf(m, 9'(v));
      ones += int'(b);
      sig = {sig[14:0], 1'b0} ^ ((sig[15] ^ b) ? 16'h1021 : 16'h0000);
    end
  endtask

  // Pulses (or holds) START, then follows the sweep; vector n/(settle+1) expected after edge n
  task automatic run_sweep(input bit s3, input int m, input bit hold,
                           output int cyc, output int verr);
    int settle;
    int n;
    settle = s3 ? 3 : 1;
    sel  = s3;
    mode = m;
    verr = 0;
    cyc  = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    n = 0;
    while (n < 2200 && cyc < 0) begin
      if (done_s) cyc = n;
      else if (vec_s !== 9'(n / (settle + 1)) || !busy_s) verr++;
      if (cyc < 0) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
  endtask

  task automatic wait_vec(input logic [8:0] target, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(posedge clk);
      #1;
      if (vec_s == target) ok = 1'b1;
    end
  endtask

  typedef struct {
    int    mode;
    int    exp_ones;
    string name;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int          cyc, verr, m_ones;
    logic [15:0] m_sig;
    bit          ok;

    tbl[0] = '{0, 512, "tie1"};
    tbl[1] = '{1, 0,   "tie0"};
    tbl[2] = '{2, 256, "loopA"};
    tbl[3] = '{3, 1,   "andAI"};
    tbl[4] = '{4, -1,  "random"};
    for (int v = 0; v < 512; v++) rnd[v] = 1'($urandom);

    rst = 1'b1; start = 1'b0; sel = 1'b0; mode = 0;
`ifdef SWEEP_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_ones", ones1, 0);
    check("rst_sig", sig1, 16'hFFFF);
    check("rst_vec", vec1, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < 5; t++) begin
      model(tbl[t].mode, m_ones, m_sig);
      run_sweep(1'b0, tbl[t].mode, 1'b0, cyc, verr);
      $display("sweep %s: cycles=%0d ones=%0d sig=%h", tbl[t].name, cyc, ones1, sig1);
      check({tbl[t].name, "_cycles"}, cyc, 1024);
      check({tbl[t].name, "_vecseq"}, verr, 0);
      check({tbl[t].name, "_ones_model"}, ones1, m_ones);
      check({tbl[t].name, "_sig_model"}, sig1, m_sig);
      if (tbl[t].exp_ones >= 0) check({tbl[t].name, "_ones_const"}, ones1, tbl[t].exp_ones);
      check({tbl[t].name, "_vec_idle"}, vec1, 0);
      repeat (3) @(posedge clk);
      #1;
      check({tbl[t].name, "_done_pulse"}, done1, 0);
      check({tbl[t].name, "_busy_after"}, busy1, 0);
      check({tbl[t].name, "_ones_hold"}, ones1, m_ones);
      check({tbl[t].name, "_sig_hold"}, sig1, m_sig);
    end

    // SETTLE=3, X tied 0: each vector held 4 cycles, 2048 cycles total
    model(1, m_ones, m_sig);
    run_sweep(1'b1, 1, 1'b0, cyc, verr);
    check("s3_cycles", cyc, 2048);
    check("s3_vecseq", verr, 0);
    check("s3_ones", ones3, 0);
    check("s3_sig", sig3, m_sig);
    @(posedge clk);
    #1;
    check("s3_done_pulse", done3, 0);
    sel = 1'b0;

    // Reset mid-sweep at IDX=100 discards partial results
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_vec(9'd100, ok);
    check("midrst_reached", ok, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", busy1, 0);
    check("midrst_done", done1, 0);
    check("midrst_ones", ones1, 0);
    check("midrst_sig", sig1, 16'hFFFF);
    check("midrst_vec", vec1, 0);
    @(negedge clk);
    rst = 1'b0;
    run_sweep(1'b0, 2, 1'b0, cyc, verr);
    check("postrst_cycles", cyc, 1024);
    check("postrst_vecseq", verr, 0);
    check("postrst_ones", ones1, 256);

    // START held high: ignored while busy, accepted again in the DONE cycle
    run_sweep(1'b0, 0, 1'b1, cyc, verr);
    check("hold_cycles", cyc, 1024);
    check("hold_vecseq", verr, 0);
    check("hold_ones", ones1, 512);
    @(posedge clk);
    #1;
    check("hold_restart_busy", busy1, 1);
    check("hold_restart_ones", ones1, 0);
    check("hold_restart_sig", sig1, 16'hFFFF);
    check("hold_restart_vec", vec1, 0);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

`ifdef SWEEP_ABORT_EN
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_vec(9'd10, ok);
    check("abort_reached", ok, 1);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", busy1, 0);
    check("abort_vec", vec1, 0);
    check("abort_done", done1, 0);
    check("abort_ones", ones1, 10);
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_done_later", done1, 0);
    check("abort_ones_hold", ones1, 10);
    @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("abort_idle_ignored", busy1, 1);
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
